// File: rtl/eight_bit_adder_checker.sv
// Exhaustive response checker for a bits-wide adder: walks {CarryIN,A,B} from 0 to
// all-ones, compares each accepted response to A+B+CarryIN and counts failures.
module eight_bit_adder_checker #(
    parameter int bits = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                InValid,
    output logic                InReady,
    input  logic [bits-1:0]     A,
    input  logic [bits-1:0]     B,
    input  logic                CarryIN,
    input  logic [bits-1:0]     Sum,
    input  logic                CarryOUT,
    output logic                Busy,
    output logic                Done,
    output logic                Pass,
    output logic [2*bits+1:0]   ErrorCount,
    output logic [2*bits+1:0]   VectorCount,
    output logic [2*bits:0]     FirstFail,
    output logic                FirstFailValid
);

    localparam int VW = 2*bits+1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [VW-1:0]   exp_idx;
    logic [VW-1:0]   vec;
    logic [bits:0]   ref_sum;
    logic            xfer, fail, last, start_run;

    assign vec       = {CarryIN, A, B};
    assign ref_sum   = {1'b0, A} + {1'b0, B} + {{bits{1'b0}}, CarryIN};
    assign fail      = ({CarryOUT, Sum} != ref_sum) || (vec != exp_idx);
    assign xfer      = InValid && (state == RUN);
    assign last      = &exp_idx;
    assign start_run = Start && (state != RUN);

    always_comb begin
        state_next = state;
        InReady    = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        Pass       = 1'b0;
        case (state)
            IDLE: if (Start) state_next = RUN;
            RUN: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                if (xfer && last) state_next = DONE;
            end
            DONE: begin
                Done = 1'b1;
                Pass = (ErrorCount == '0);
                if (Start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= IDLE;
            exp_idx        <= '0;
            ErrorCount     <= '0;
            VectorCount    <= '0;
            FirstFail      <= '0;
            FirstFailValid <= 1'b0;
        end else begin
            state <= state_next;
            if (start_run) begin
                exp_idx        <= '0;
                ErrorCount     <= '0;
                VectorCount    <= '0;
                FirstFail      <= '0;
                FirstFailValid <= 1'b0;
            end else if (xfer) begin
                VectorCount <= VectorCount + {{VW{1'b0}}, 1'b1};
                // Hold the index at all-ones on the final transfer so it never starts a second pass.
                if (!last) exp_idx <= exp_idx + {{(VW-1){1'b0}}, 1'b1};
                if (fail) begin
                    ErrorCount <= ErrorCount + {{VW{1'b0}}, 1'b1};
                    if (!FirstFailValid) begin
                        FirstFail      <= vec;
                        FirstFailValid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_eight_bit_adder_checker.sv
// Randomized self-checking bench for eight_bit_adder_checker (bits=2, 32-vector runs)
// against an arithmetic reference model of the checker's observable behaviour.
module tb_eight_bit_adder_checker;

    localparam int W  = 2;
    localparam int NV = 1 << (2*W+1);

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic             InValid = 1'b0;
    logic             InReady;
    logic [W-1:0]     A = '0, B = '0, Sum = '0;
    logic             CarryIN = 1'b0, CarryOUT = 1'b0;
    logic             Busy, Done, Pass, FirstFailValid;
    logic [2*W+1:0]   ErrorCount, VectorCount;
    logic [2*W:0]     FirstFail;

    eight_bit_adder_checker #(.bits(W)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .CarryIN(CarryIN), .Sum(Sum), .CarryOUT(CarryOUT),
        .Busy(Busy), .Done(Done), .Pass(Pass), .ErrorCount(ErrorCount),
        .VectorCount(VectorCount), .FirstFail(FirstFail), .FirstFailValid(FirstFailValid)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    // Reference model: 0 = idle, 1 = running, 2 = done
    int m_state = 0, m_e = 0, m_vc = 0, m_ec = 0, m_ff = 0;
    bit m_ffv = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int correct(input int vec);
        int ci, a, b;
        ci = vec >> (2*W);
        a  = (vec >> W) & ((1 << W) - 1);
        b  = vec & ((1 << W) - 1);
        return a + b + ci;
    endfunction

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    // One cycle of stimulus; the model consumes it with the same pre-edge state as the DUT.
    task automatic xfer(input int vec, input int resp, input bit valid, input bit st);
        CarryIN  = vec[2*W];
        A        = vec[2*W-1:W];
        B        = vec[W-1:0];
        {CarryOUT, Sum} = resp[W:0];
        InValid  = valid;
        Start    = st;
        if (st && m_state != 1) begin
            m_state = 1; m_e = 0; m_vc = 0; m_ec = 0; m_ff = 0; m_ffv = 0;
        end else if (valid && m_state == 1) begin
            m_vc++;
            if (resp != correct(vec) || vec != m_e) begin
                m_ec++;
                if (!m_ffv) begin m_ffv = 1; m_ff = vec; end
            end
            if (m_e == NV-1) m_state = 2;
            else m_e++;
        end
        tick;
        InValid = 1'b0;
        Start   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"}, InReady, m_state == 1);
        chk({tag, ".busy"},  Busy,    m_state == 1);
        chk({tag, ".done"},  Done,    m_state == 2);
        chk({tag, ".pass"},  Pass,    m_state == 2 && m_ec == 0);
        chk({tag, ".ec"},    ErrorCount, m_ec);
        chk({tag, ".vc"},    VectorCount, m_vc);
        chk({tag, ".ff"},    FirstFail, m_ff);
        chk({tag, ".ffv"},   FirstFailValid, m_ffv);
    endtask

    initial begin
        int v, guard;
        bit val;
        tick; tick;
        Reset = 1'b0;
        check_all("reset");

        // Valid data while idle is ignored
        xfer(5, correct(5), 1, 0);
        check_all("idle_ignore");

        // Clean in-order run
        xfer(0, 0, 0, 1);
        check_all("start_a");
        for (int i = 0; i < NV; i++) xfer(i, correct(i), 1, 0);
        check_all("run_a");
        chk("run_a.vc32", VectorCount, 32);
        chk("run_a.pass", Pass, 1);

        // Restart from DONE; bad sum at E=13
        xfer(0, 0, 0, 1);
        check_all("restart");
        for (int i = 0; i < NV; i++) xfer(i, (i == 13) ? 0 : correct(i), 1, 0);
        check_all("run_b");
        chk("run_b.ff13", FirstFail, 5'b01101);
        // Outputs frozen in DONE while junk is offered
        for (int i = 0; i < 3; i++) begin
            v = $urandom_range(0, NV-1);
            xfer(v, $urandom_range(0, 7), 1, 0);
        end
        check_all("done_hold");

        // Random InValid gaps, junk data on idle cycles
        xfer(0, 0, 0, 1);
        guard = 0;
        while (m_state == 1 && guard < 400) begin
            val = 1'($urandom_range(0, 1));
            v = val ? m_e : int'($urandom_range(0, NV-1));
            xfer(v, val ? correct(v) : int'($urandom_range(0, 7)), val, 0);
            chk("gap.vc", VectorCount, m_vc);
            guard++;
        end
        check_all("run_c");
        chk("run_c.done", Done, 1);

        // E=3 skipped (vector 4 sent at E=3); Start mid-run must be ignored
        xfer(0, 0, 0, 1);
        for (int i = 0; i < NV; i++) begin
            v = (i == 3) ? 4 : i;
            xfer(v, correct(v), 1, i == 10);
        end
        check_all("run_d");
        chk("run_d.ff4", FirstFail, 5'b00100);
        chk("run_d.ec_ge1", ErrorCount >= 1, 1);

        // Reset with Start and a transfer in the same cycle, mid-run
        xfer(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) xfer(i, correct(i), 1, 0);
        chk("pre_rst.vc", VectorCount, 10);
        Reset = 1'b1; Start = 1'b1; InValid = 1'b1;
        CarryIN = 1'b0; A = 2'd2; B = 2'd2; {CarryOUT, Sum} = 3'd4;
        tick;
        Reset = 1'b0; Start = 1'b0; InValid = 1'b0;
        m_state = 0; m_e = 0; m_vc = 0; m_ec = 0; m_ff = 0; m_ffv = 0;
        check_all("rst_mid");
        tick;
        check_all("rst_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
